// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM encoding, register-index zero and default counter width.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of pipeline status inputs and register-control outputs exchanged
// between the datapath (master) and the hazard controller (slave).
interface pipeline_ctrl_if import pipeline_ctrl_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) ();
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_ld;
    logic [4:0]       ex_rd;
    logic             ex_halt;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             wb_halt;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_write;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_ld, ex_rd,
               ex_halt, ex_branch_taken, mem_req, mem_ready, wb_halt,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, memwb_write, halted, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_ld, ex_rd,
               ex_halt, ex_branch_taken, mem_req, mem_ready, wb_halt,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, memwb_write, halted, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, branch
// squashes, data-memory freezes and halt draining, plus perf counters.
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    pipeline_ctrl_if.slave  bus
);
    state_e state_q, state_d;
    logic   freeze;
    logic   load_use;
    logic   stall_inc;
    logic   flush_inc;

    assign freeze   = bus.mem_req && !bus.mem_ready;
    assign load_use = bus.ex_ld && (bus.ex_rd != REG_ZERO) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_write  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_write = 1'b0;
        bus.memwb_write = 1'b0;
        bus.halted      = 1'b0;
        flush_inc       = 1'b0;
        case (state_q)
            RUN: begin
                if (!freeze) begin
                    // Flushed registers keep their write enable so they latch the bubble.
                    bus.ifid_write  = 1'b1;
                    bus.idex_write  = 1'b1;
                    bus.exmem_write = 1'b1;
                    bus.memwb_write = 1'b1;
                    if (bus.ex_halt) begin
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                        state_d        = DRAIN;
                    end else if (bus.ex_branch_taken) begin
                        bus.pc_write   = 1'b1;
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                        flush_inc      = 1'b1;
                    end else if (load_use) begin
                        bus.ifid_write = 1'b0;
                        bus.idex_flush = 1'b1;
                    end else begin
                        bus.pc_write = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!freeze) begin
                    bus.ifid_write  = 1'b1;
                    bus.ifid_flush  = 1'b1;
                    bus.idex_write  = 1'b1;
                    bus.idex_flush  = 1'b1;
                    bus.exmem_write = 1'b1;
                    bus.memwb_write = 1'b1;
                    if (bus.wb_halt) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign stall_inc = !bus.pc_write && (state_q != HALTED);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (stall_inc),
        .count_o (bus.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (flush_inc),
        .count_o (bus.flush_count)
    );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a 32-bit and a 4-bit counter instance
// share the same stimulus and are checked against a behavioural model.
module tb_pipeline_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();
    pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.id_rs1          = bus.id_rs1;
    assign bus4.id_rs2          = bus.id_rs2;
    assign bus4.id_use_rs1      = bus.id_use_rs1;
    assign bus4.id_use_rs2      = bus.id_use_rs2;
    assign bus4.ex_ld           = bus.ex_ld;
    assign bus4.ex_rd           = bus.ex_rd;
    assign bus4.ex_halt         = bus.ex_halt;
    assign bus4.ex_branch_taken = bus.ex_branch_taken;
    assign bus4.mem_req         = bus.mem_req;
    assign bus4.mem_ready       = bus.mem_ready;
    assign bus4.wb_halt         = bus.wb_halt;

    pipeline_ctrl #(.CNT_W(32)) dut   (.clock(clock), .reset(reset), .bus(bus));
    pipeline_ctrl #(.CNT_W(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4));

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       ex_ld;
        logic [4:0] ex_rd;
        logic       ex_halt;
        logic       br;
        logic       mem_req;
        logic       mem_ready;
        logic       wb_halt;
    } stim_t;

    typedef struct {
        logic [6:0] ctl;   // {pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w}
        logic       halted;
        longint     stall;
        longint     flush;
        string      tag;
    } exp_t;

    exp_t   sbq[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    // model: 0 running, 1 draining, 2 stopped
    int     m_mode   = 0;
    longint m_stall  = 0;
    longint m_flush  = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_rs1          = s.rs1;
        bus.id_rs2          = s.rs2;
        bus.id_use_rs1      = s.use1;
        bus.id_use_rs2      = s.use2;
        bus.ex_ld           = s.ex_ld;
        bus.ex_rd           = s.ex_rd;
        bus.ex_halt         = s.ex_halt;
        bus.ex_branch_taken = s.br;
        bus.mem_req         = s.mem_req;
        bus.mem_ready       = s.mem_ready;
        bus.wb_halt         = s.wb_halt;
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.mem_ready = 1'b1;
        return s;
    endfunction

    // One clock of stimulus: predict the outputs, queue them, advance the model.
    task automatic step(input stim_t s, input string tag);
        exp_t e;
        bit   waiting, dep, count_br;
        int   nxt;
        apply(s);
        waiting  = s.mem_req && !s.mem_ready;
        dep      = s.ex_ld && s.ex_rd != 0 &&
                   ((s.use1 && s.rs1 == s.ex_rd) || (s.use2 && s.rs2 == s.ex_rd));
        nxt      = m_mode;
        count_br = 0;
        if (m_mode == 2 || waiting)        e.ctl = 7'b0000000;
        else if (m_mode == 1) begin        e.ctl = 7'b0111111; if (s.wb_halt) nxt = 2; end
        else if (s.ex_halt) begin          e.ctl = 7'b0111111; nxt = 1; end
        else if (s.br) begin               e.ctl = 7'b1111111; count_br = 1; end
        else if (dep)                      e.ctl = 7'b0001111;
        else                               e.ctl = 7'b1101011;
        e.halted = (m_mode == 2);
        e.stall  = m_stall;
        e.flush  = m_flush;
        e.tag    = tag;
        sbq.push_back(e);
        @(posedge clock);
        if (!e.ctl[6] && m_mode != 2) m_stall++;
        if (count_br) m_flush++;
        m_mode = nxt;
        #1;
    endtask

    task automatic do_reset(input string tag);
        apply(idle());
        reset = 1'b1;
        #2;
        chk({tag, "_rst_pc_write"}, longint'(bus.pc_write), 1);
        chk({tag, "_rst_halted"},   longint'(bus.halted), 0);
        chk({tag, "_rst_stall"},    longint'(bus.stall_cycles), 0);
        chk({tag, "_rst_flush"},    longint'(bus.flush_count), 0);
        chk({tag, "_rst_stall4"},   longint'(bus4.stall_cycles), 0);
        $display("[%0t] reset %s", $time, tag);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        m_mode  = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    always @(negedge clock) begin
        if (sbq.size() > 0) begin
            exp_t e;
            logic [6:0] ctl;
            e   = sbq.pop_front();
            ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
                   bus.idex_flush, bus.exmem_write, bus.memwb_write};
            $display("[%0t] %s ctl=%b halted=%0b stall=%0d flush=%0d", $time, e.tag,
                     ctl, bus.halted, bus.stall_cycles, bus.flush_count);
            chk({e.tag, "_ctl"},    longint'(ctl), longint'(e.ctl));
            chk({e.tag, "_halted"}, longint'(bus.halted), longint'(e.halted));
            chk({e.tag, "_stall"},  longint'(bus.stall_cycles), e.stall);
            chk({e.tag, "_flush"},  longint'(bus.flush_count), e.flush);
            chk({e.tag, "_stall4"}, longint'(bus4.stall_cycles), sat4(e.stall));
            chk({e.tag, "_flush4"}, longint'(bus4.flush_count), sat4(e.flush));
        end
    end

    initial begin
        stim_t s;
        do_reset("init");
        step(idle(), "idle");
        step(idle(), "idle");

        s = idle(); s.ex_ld = 1; s.ex_rd = 5; s.rs1 = 5; s.use1 = 1;
        step(s, "loaduse");
        step(idle(), "after_lu");

        s = idle(); s.ex_ld = 1; s.ex_rd = 0; s.rs1 = 0; s.use1 = 1;
        step(s, "ld_x0");
        s = idle(); s.ex_ld = 1; s.ex_rd = 7; s.rs1 = 3; s.rs2 = 7; s.use1 = 1; s.use2 = 0;
        step(s, "unused_rs2");

        s = idle(); s.ex_ld = 1; s.ex_rd = 9; s.rs2 = 9; s.use2 = 1; s.br = 1;
        step(s, "br_vs_lu");
        step(idle(), "after_br");

        s = idle(); s.br = 1; s.mem_req = 1; s.mem_ready = 0;
        for (int i = 0; i < 3; i++) step(s, "memwait");
        s.mem_ready = 1;
        step(s, "memdone_br");
        step(idle(), "after_mem");

        s = idle(); s.ex_halt = 1; s.br = 1;
        step(s, "halt_ex");
        s = idle(); s.mem_req = 1; s.mem_ready = 0; s.wb_halt = 1;
        step(s, "drain_frz");
        step(s, "drain_frz");
        step(idle(), "drain");
        s = idle(); s.wb_halt = 1;
        step(s, "drain_wb");
        for (int i = 0; i < 3; i++) step(idle(), "halted");
        s = idle(); s.br = 1; s.ex_ld = 1; s.ex_rd = 2; s.rs1 = 2; s.use1 = 1;
        step(s, "halted_busy");
        do_reset("after_halt");

        s = idle(); s.ex_halt = 1;
        step(s, "halt_ex2");
        s = idle(); s.mem_req = 1; s.mem_ready = 0;
        step(s, "drain_frz2");
        do_reset("mid_freeze");

        s = idle(); s.ex_ld = 1; s.ex_rd = 4; s.rs1 = 4; s.use1 = 1;
        for (int i = 0; i < 20; i++) step(s, "sat_lu");
        s = idle(); s.br = 1;
        for (int i = 0; i < 20; i++) step(s, "sat_br");
        do_reset("after_sat");

        for (int n = 0; n < 400; n++) begin
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
                do_reset("rand");
            end else begin
                s.rs1       = 5'($urandom_range(0, 3));
                s.rs2       = 5'($urandom_range(0, 3));
                s.use1      = 1'($urandom_range(0, 1));
                s.use2      = 1'($urandom_range(0, 1));
                s.ex_ld     = 1'($urandom_range(0, 1));
                s.ex_rd     = 5'($urandom_range(0, 3));
                s.ex_halt   = ($urandom_range(0, 39) == 0);
                s.br        = ($urandom_range(0, 4) == 0);
                s.mem_req   = ($urandom_range(0, 2) == 0);
                s.mem_ready = 1'($urandom_range(0, 1));
                s.wb_halt   = ($urandom_range(0, 3) == 0);
                step(s, "rand");
            end
        end

        @(negedge clock);
        chk("scoreboard_drained", longint'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It generates write-enable and flush (bubble) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves four conditions: load-use hazards, taken-branch squashes, data-memory wait freezes, and halt draining. It also keeps stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_ld  in  1  ld control bit from ID/EX (load in EX)
- ex_rd  in  5  rd from ID/EX
- ex_halt  in  1  halt control bit from ID/EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_req  in  1  EX/MEM holds a load or store
- mem_ready  in  1  data memory completes access this cycle
- wb_halt  in  1  halt control bit from MEM/WB
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_write  out  1  ID/EX load enable (ID/EX gains this enable)
- idex_flush  out  1  ID/EX control inputs forced to 0 (bubble)
- exmem_write, memwb_write  out  1  later-stage load enables
- halted  out  1  processor stopped
- stall_cycles  out  CNT_W  cycles with pc_write=0 while not HALTED
- flush_count  out  CNT_W  taken-branch squash events

## Operation
FSM states: RUN, DRAIN, HALTED.

Controls are combinational from inputs and state. Priorities run highest first:
1. **freeze** = mem_req && !mem_ready, in RUN or DRAIN.
   - All *_write = 0, all flushes = 0.
   - The counters still count stall_cycles.
2. **halt_ex** = ex_halt in RUN.
   - pc_write=0, ifid_flush=1, idex_flush=1.
   - Next state is DRAIN.
3. **branch** = ex_branch_taken in RUN.
   - pc_write=1 (target), ifid_flush=1, idex_flush=1.
   - flush_count +1.
4. **load_use** = ex_ld && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
   - pc_write=0, ifid_write=0, idex_flush=1.
   - Load-use is ignored whenever branch is active, because the ID instruction is wrong-path.
5. **Otherwise**: all *_write=1, flushes=0.

DRAIN:
- pc_write=0, ifid_flush=1, idex_flush=1.
- exmem_write and memwb_write = !freeze.
- Next state is HALTED on wb_halt && !freeze.

HALTED:
- All *_write=0, flushes=0, halted=1.
- HALTED is sticky until reset.
- The counters hold.

Counters:
- stall_cycles increments when pc_write=0 and the state is not HALTED.
- Both counters saturate at all-ones and never wrap.

A flush on a register overrides its write enable: a flushed register loads the bubble.

## Timing
- Reset values:
  - State = RUN, counters = 0, halted = 0.
  - In RUN with idle inputs, all *_write = 1 and flushes = 0.
- All outputs are combinational from the current inputs and state, with zero-cycle latency. The state and counters update on the clock edge.
- Load-use inserts exactly 1 bubble. On the next cycle ex_ld is 0 (bubble), so the hazard clears.
- A taken branch squashes exactly 2 younger instructions (IF/ID and ID/EX) in the same cycle.
- Freeze holds the stall for as many cycles as mem_ready stays low. The condition that froze (branch, halt, or load-use) is re-evaluated on the first unfrozen cycle.
- ex_halt and ex_branch_taken cannot be asserted by the same instruction. If both are high, halt wins.
- Reset mid-DRAIN or mid-freeze returns to RUN with counters 0 immediately (asynchronous).

## Structure
- A shared pipeline package holds:
  - the state enum (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2);
  - the register-index zero constant;
  - CNT_W default.
- The hazard compare is inline logic.
- One sub-module: sat_counter (parameter W; inc input; saturating). It is instantiated twice.

## Test plan
- **Load-use:** ld x5 in EX, ID reads x5 as rs1 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; next cycle all writes=1; stall_cycles=1.
- **x0 / unused source:** ld x0 in EX with ID rs1=x0 → no stall. ld x7 with id_use_rs2=0 and id_rs2=7 → no stall.
- **Branch vs load-use:** ex_branch_taken=1 together with a load-use match → pc_write=1, ifid_flush=1, idex_flush=1; flush_count=1; stall_cycles unchanged.
- **Memory wait:** mem_req=1 and mem_ready=0 for 3 cycles while a branch is taken → all writes=0 for 3 cycles; the squash occurs on cycle 4; stall_cycles=3.
- **Halt:**
  - ex_halt=1 → DRAIN. A freeze during DRAIN holds the state. wb_halt=1 → halted=1 the next cycle.
  - All writes stay 0 afterwards. Asserting reset returns to RUN.
- **Saturation:** with CNT_W=4, hold load-use for 20 cycles → stall_cycles stays at 15.
